// File: rtl/lr2_seq_decoder.sv
// Classifies each LR2 counter step as UP/DOWN/HOLD/JUMP against the previous sample,
// keeps saturating event counters and a run-length filtered direction flag.
module lr2_seq_decoder #(
  parameter int CNT_W   = 8,
  parameter int RUN_MIN = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             CLR,
  input  logic [3:0]       SEQ_I,
  output logic             VALID_O,
  output logic [2:0]       CODE_O,
  output logic             DIR_O,
  output logic [CNT_W-1:0] UP_CNT,
  output logic [CNT_W-1:0] DN_CNT,
  output logic [CNT_W-1:0] JMP_CNT
);

  typedef enum logic {ST_EMPTY, ST_TRACK} state_t;

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_UP    = 3'd1;
  localparam logic [2:0] CODE_DOWN  = 3'd2;
  localparam logic [2:0] CODE_HOLD  = 3'd3;
  localparam logic [2:0] CODE_JUMP  = 3'd4;
  localparam logic [2:0] CODE_FIRST = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       RUN_MIN_L = 4'(RUN_MIN);

  state_t           state_q, state_d;
  logic [3:0]       last_q, last_d;
  logic             valid_q, valid_d;
  logic [2:0]       code_q, code_d;
  logic             dir_q, dir_d;
  logic [3:0]       run_q, run_d;
  logic             rsgn_q, rsgn_d;
  logic [CNT_W-1:0] up_cnt_q, up_cnt_d;
  logic [CNT_W-1:0] dn_cnt_q, dn_cnt_d;
  logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;
  logic [3:0]       delta;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    dir_d     = dir_q;
    run_d     = run_q;
    rsgn_d    = rsgn_q;
    up_cnt_d  = up_cnt_q;
    dn_cnt_d  = dn_cnt_q;
    jmp_cnt_d = jmp_cnt_q;
    delta     = SEQ_I - last_q;

    if (CLR) begin
      up_cnt_d  = '0;
      dn_cnt_d  = '0;
      jmp_cnt_d = '0;
      run_d     = 4'd0;
      rsgn_d    = 1'b1;
      last_d    = 4'd0;
      state_d   = ST_EMPTY;
    end

    if (CE) begin
      valid_d = 1'b1;
      last_d  = SEQ_I;
      // A clear on the same cycle discards history, so this sample starts a new track
      if (CLR || state_q == ST_EMPTY) begin
        code_d  = CODE_FIRST;
        run_d   = 4'd0;
        state_d = ST_TRACK;
      end else begin
        case (delta)
          4'd1: begin
            code_d   = CODE_UP;
            up_cnt_d = sat_inc(up_cnt_q);
            if (rsgn_q) begin
              run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
            end else begin
              run_d  = 4'd1;
              rsgn_d = 1'b1;
            end
          end
          4'd15: begin
            code_d   = CODE_DOWN;
            dn_cnt_d = sat_inc(dn_cnt_q);
            if (!rsgn_q) begin
              run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
            end else begin
              run_d  = 4'd1;
              rsgn_d = 1'b0;
            end
          end
          4'd0: code_d = CODE_HOLD;
          default: begin
            code_d    = CODE_JUMP;
            jmp_cnt_d = sat_inc(jmp_cnt_q);
            run_d     = 4'd0;
          end
        endcase
      end
      if (run_d >= RUN_MIN_L && rsgn_d != dir_q) begin
        dir_d = rsgn_d;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_EMPTY;
      last_q    <= 4'd0;
      valid_q   <= 1'b0;
      code_q    <= CODE_NONE;
      dir_q     <= 1'b1;
      run_q     <= 4'd0;
      rsgn_q    <= 1'b1;
      up_cnt_q  <= '0;
      dn_cnt_q  <= '0;
      jmp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      dir_q     <= dir_d;
      run_q     <= run_d;
      rsgn_q    <= rsgn_d;
      up_cnt_q  <= up_cnt_d;
      dn_cnt_q  <= dn_cnt_d;
      jmp_cnt_q <= jmp_cnt_d;
    end
  end

  assign VALID_O = valid_q;
  assign CODE_O  = code_q;
  assign DIR_O   = dir_q;
  assign UP_CNT  = up_cnt_q;
  assign DN_CNT  = dn_cnt_q;
  assign JMP_CNT = jmp_cnt_q;

endmodule

// File: tb/tb_lr2_seq_decoder.sv
// Directed bench for lr2_seq_decoder: a step-level reference model checked every cycle,
// plus hand-computed literal expectations along the documented scenarios.
module tb_lr2_seq_decoder;

  localparam int CNT_W   = 4;
  localparam int RUN_MIN = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             CE = 1'b0;
  logic             CLR = 1'b0;
  logic [3:0]       SEQ_I = 4'd0;
  logic             VALID_O;
  logic [2:0]       CODE_O;
  logic             DIR_O;
  logic [CNT_W-1:0] UP_CNT;
  logic [CNT_W-1:0] DN_CNT;
  logic [CNT_W-1:0] JMP_CNT;

  int passCount = 0;
  int checkCount = 0;

  // Reference model state
  bit mHave = 0;
  int mLast = 0;
  bit mValid = 0;
  int mCode = 0;
  bit mDir = 1;
  int mRun = 0;
  bit mRsgn = 1;
  int mUp = 0;
  int mDn = 0;
  int mJmp = 0;

  lr2_seq_decoder #(.CNT_W(CNT_W), .RUN_MIN(RUN_MIN)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .SEQ_I(SEQ_I),
    .VALID_O(VALID_O), .CODE_O(CODE_O), .DIR_O(DIR_O),
    .UP_CNT(UP_CNT), .DN_CNT(DN_CNT), .JMP_CNT(JMP_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic int satInc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // A directional step extends the current run or starts a new one of length 1
  task automatic modelDirStep(input bit up);
    if (mRsgn == up) begin
      mRun = (mRun >= 15) ? 15 : mRun + 1;
    end else begin
      mRun = 1;
      mRsgn = up;
    end
  endtask

  task automatic modelStep(input bit rst, input bit ce, input bit clr, input int seq);
    int d;
    if (!rst) begin
      mHave = 0; mLast = 0; mValid = 0; mCode = 0;
      mDir = 1; mRun = 0; mRsgn = 1; mUp = 0; mDn = 0; mJmp = 0;
      return;
    end
    mValid = 0;
    if (clr) begin
      mUp = 0; mDn = 0; mJmp = 0; mRun = 0; mRsgn = 1; mLast = 0; mHave = 0;
    end
    if (ce) begin
      if (!mHave) begin
        mCode = 5;
        mRun = 0;
        mHave = 1;
      end else begin
        d = (seq - mLast + 16) % 16;
        if (d == 1) begin
          mCode = 1; mUp = satInc(mUp); modelDirStep(1'b1);
        end else if (d == 15) begin
          mCode = 2; mDn = satInc(mDn); modelDirStep(1'b0);
        end else if (d == 0) begin
          mCode = 3;
        end else begin
          mCode = 4; mJmp = satInc(mJmp); mRun = 0;
        end
      end
      mLast = seq;
      mValid = 1;
      if (mRun >= RUN_MIN && mRsgn != mDir) mDir = mRsgn;
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkOutput();
    check("valid", int'(VALID_O), int'(mValid));
    check("code", int'(CODE_O), mCode);
    check("dir", int'(DIR_O), int'(mDir));
    check("up_cnt", int'(UP_CNT), mUp);
    check("dn_cnt", int'(DN_CNT), mDn);
    check("jmp_cnt", int'(JMP_CNT), mJmp);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare in the low phase
  task automatic applyStimulus(input bit rst, input bit ce, input bit clr, input logic [3:0] seq);
    RST = rst; CE = ce; CLR = clr; SEQ_I = seq;
    @(posedge CLK);
    modelStep(rst, ce, clr, int'(seq));
    @(negedge CLK);
    RST = 1'b1; CE = 1'b0; CLR = 1'b0;
    checkOutput();
  endtask

  task automatic stepCe(input logic [3:0] seq);
    applyStimulus(1'b1, 1'b1, 1'b0, seq);
  endtask

  initial begin
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    check("lit_reset_code", int'(CODE_O), 0);
    check("lit_reset_dir", int'(DIR_O), 1);
    check("lit_reset_valid", int'(VALID_O), 0);

    // Up run 3,4,5,6
    stepCe(4'd3);
    check("lit_first_code", int'(CODE_O), 5);
    check("lit_first_valid", int'(VALID_O), 1);
    stepCe(4'd4); stepCe(4'd5); stepCe(4'd6);
    check("lit_up_cnt3", int'(UP_CNT), 3);
    check("lit_up_code", int'(CODE_O), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    check("lit_idle_valid", int'(VALID_O), 0);
    check("lit_idle_code_hold", int'(CODE_O), 1);

    // Jump to 1, then down run 0,F,E,D
    stepCe(4'd1);
    check("lit_jump_code", int'(CODE_O), 4);
    stepCe(4'd0); stepCe(4'hF);
    check("lit_dir_after_2dn", int'(DIR_O), 1);
    stepCe(4'hE);
    check("lit_dir_after_3dn", int'(DIR_O), 0);
    stepCe(4'hD);
    check("lit_dn_cnt4", int'(DN_CNT), 4);
    check("lit_dn_code", int'(CODE_O), 2);

    // Clear alone, then wrap and hold: E,F,0,0,1
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
    check("lit_clr_up", int'(UP_CNT), 0);
    check("lit_clr_dir_kept", int'(DIR_O), 0);
    stepCe(4'hE); check("lit_wrap_first", int'(CODE_O), 5);
    stepCe(4'hF); check("lit_wrap_up1", int'(CODE_O), 1);
    stepCe(4'h0); check("lit_wrap_up2", int'(CODE_O), 1);
    stepCe(4'h0); check("lit_wrap_hold", int'(CODE_O), 3);
    stepCe(4'h1); check("lit_wrap_up3", int'(CODE_O), 1);
    check("lit_wrap_up_cnt", int'(UP_CNT), 3);
    check("lit_wrap_jmp_cnt", int'(JMP_CNT), 0);
    check("lit_wrap_dir", int'(DIR_O), 1);

    // Jump resets the filter
    stepCe(4'd2); stepCe(4'd3); stepCe(4'd4);
    stepCe(4'hA);
    check("lit_jmpA_code", int'(CODE_O), 4);
    check("lit_jmpA_cnt", int'(JMP_CNT), 1);
    stepCe(4'd9); stepCe(4'd8);
    check("lit_jmp_dir_held", int'(DIR_O), 1);
    stepCe(4'd7);
    check("lit_jmp_dir_flip", int'(DIR_O), 0);

    // Saturation with CNT_W=4
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    check("lit_sat_first", int'(CODE_O), 5);
    for (int i = 1; i < 16; i++) stepCe(4'(i));
    check("lit_sat_15", int'(UP_CNT), 15);
    stepCe(4'd0);
    check("lit_sat_hold", int'(UP_CNT), 15);
    check("lit_sat_code", int'(CODE_O), 1);

    // Clear with CE mid-run
    stepCe(4'hF); stepCe(4'hE); stepCe(4'hD);
    check("lit_mid_dir", int'(DIR_O), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd9);
    check("lit_clrce_code", int'(CODE_O), 5);
    check("lit_clrce_up", int'(UP_CNT), 0);
    check("lit_clrce_dn", int'(DN_CNT), 0);
    check("lit_clrce_dir", int'(DIR_O), 0);
    stepCe(4'hA);
    check("lit_clrce_next_code", int'(CODE_O), 1);
    check("lit_clrce_next_up", int'(UP_CNT), 1);

    // Reset between CEs, overriding CE
    stepCe(4'hB);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hC);
    check("lit_rst_valid", int'(VALID_O), 0);
    check("lit_rst_code", int'(CODE_O), 0);
    check("lit_rst_dir", int'(DIR_O), 1);
    check("lit_rst_up", int'(UP_CNT), 0);
    stepCe(4'd5);
    check("lit_rst_first", int'(CODE_O), 5);
    check("lit_rst_first_valid", int'(VALID_O), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
